// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    // All segments off (segments are active-low).
    localparam seg_t SEG_OFF = 7'h7F;

    typedef enum logic {
        DWELL = 1'b0,
        GAP   = 1'b1
    } scan_state_t;

    // Largest of three values; sizes the shared dwell/gap down-counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern (seg[0]=a .. seg[6]=g).
module hex_to_seg
    import sevseg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    // Glyph lookup for 0-9, A, b, C, d, E, F.
    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with shadow/active digit
// registers, frame-boundary update and an all-dark gap between digit dwells.
// Optional feature: define SEVSEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 50
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int CNT_W = $clog2(max3(DIGIT_CYCLES, BLANK_CYCLES, 2));
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1)
                                                                 : {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                 state_r, state_nx_s;
    logic [IDX_W-1:0]            idx_r, idx_nx_s, idx_inc_s;
    logic [CNT_W-1:0]            cnt_r, cnt_nx_s;
    logic                        boundary_s;

    logic [NUM_DIGITS-1:0][3:0]  shadow_r, active_r, active_nx_s;
    logic [NUM_DIGITS-1:0]       sblank_r, ablank_r, ablank_nx_s;
    logic                        pending_r;

    logic [NUM_DIGITS-1:0]       lzb_s;
    logic                        dark_s;
    seg_t                        seg_dec_s, seg_nx_s, seg_r;
    logic [NUM_DIGITS-1:0]       an_nx_s, an_r;
    logic                        frame_start_r;

    assign idx_inc_s = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));

    // Next-state logic: count down the current phase, then step DWELL -> GAP -> next DWELL.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r;
        boundary_s = 1'b0;
        if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_nx_s = cnt_r - CNT_W'(1);
        end else begin
            case (state_r)
                DWELL: begin
                    if (BLANK_CYCLES > 0) begin
                        state_nx_s = GAP;
                        cnt_nx_s   = BLANK_LOAD;
                    end else begin
                        state_nx_s = DWELL;
                        idx_nx_s   = idx_inc_s;
                        cnt_nx_s   = DWELL_LOAD;
                    end
                end
                GAP: begin
                    state_nx_s = DWELL;
                    idx_nx_s   = idx_inc_s;
                    cnt_nx_s   = DWELL_LOAD;
                end
                default: begin
                    state_nx_s = GAP;
                    idx_nx_s   = LAST_IDX;
                    cnt_nx_s   = BLANK_LOAD;
                end
            endcase
            // The edge that enters DWELL(0) is the frame boundary.
            boundary_s = (state_nx_s == DWELL) && (idx_nx_s == {IDX_W{1'b0}});
        end
    end

    // Active copy takes the shadow only at a frame boundary with an unapplied load.
    always_comb begin
        active_nx_s = active_r;
        ablank_nx_s = ablank_r;
        if (boundary_s && pending_r) begin
            active_nx_s = shadow_r;
            ablank_nx_s = sblank_r;
        end else begin
            active_nx_s = active_r;
            ablank_nx_s = ablank_r;
        end
    end

`ifdef SEVSEG_LZB_EN
    logic zero_run_s;

    // Leading-zero mask: digit k>0 is dark if it and all more-significant digits are 0.
    always_comb begin
        lzb_s      = {NUM_DIGITS{1'b0}};
        zero_run_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run_s = zero_run_s & (active_nx_s[k] == 4'h0);
            lzb_s[k]   = zero_run_s;
        end
    end
`else
    assign lzb_s = {NUM_DIGITS{1'b0}};
`endif

    assign dark_s = ablank_nx_s[idx_nx_s] | lzb_s[idx_nx_s];

    // Decode the digit being entered so the registered outputs track the new state.
    hex_to_seg u_dec (
        .hex (active_nx_s[idx_nx_s]),
        .seg (seg_dec_s)
    );

    // Next output values: one anode low during a lit dwell, everything off otherwise.
    always_comb begin
        an_nx_s  = {NUM_DIGITS{1'b1}};
        seg_nx_s = SEG_OFF;
        if ((state_nx_s == DWELL) && !dark_s) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_nx_s[k] = (idx_nx_s != IDX_W'(k));
            end
            seg_nx_s = seg_dec_s;
        end else begin
            an_nx_s  = {NUM_DIGITS{1'b1}};
            seg_nx_s = SEG_OFF;
        end
    end

    // Scan FSM state register; reset parks in the last gap so DWELL(0) follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= GAP;
            idx_r   <= LAST_IDX;
            cnt_r   <= BLANK_LOAD;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Shadow/active digit storage and pending flag; a load on the boundary edge stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r  <= '0;
            sblank_r  <= {NUM_DIGITS{1'b0}};
            active_r  <= '0;
            ablank_r  <= {NUM_DIGITS{1'b0}};
            pending_r <= 1'b0;
        end else begin
            active_r <= active_nx_s;
            ablank_r <= ablank_nx_s;
            if (load) begin
                shadow_r  <= digits_in;
                sblank_r  <= blank_in;
                pending_r <= 1'b1;
            end else if (boundary_s) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r         <= SEG_OFF;
            an_r          <= {NUM_DIGITS{1'b1}};
            frame_start_r <= 1'b0;
        end else begin
            seg_r         <= seg_nx_s;
            an_r          <= an_nx_s;
            frame_start_r <= boundary_s;
        end
    end

    assign seg         = seg_r;
    assign an          = an_r;
    assign frame_start = frame_start_r;
    assign pending     = pending_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (NUM_DIGITS=2, DIGIT_CYCLES=4, BLANK_CYCLES=1).
// Expected per-cycle outputs of a frame are queued when a load is driven and
// popped while the frame is displayed. Honours SEVSEG_LZB_EN like the design.
module tb_seven_seg_scan;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] digits_in;
    logic [1:0] blank_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_start;
    logic       pending;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       seg_chk;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_seg_scan #(
        .NUM_DIGITS   (2),
        .DIGIT_CYCLES (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .digits_in   (digits_in),
        .blank_in    (blank_in),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic [1:0] b);
        digits_in = v;
        blank_in  = b;
        load      = 1'b1;
        @(posedge clk);
        #1;
        load      = 1'b0;
    endtask

    // Queue the ten expected cycles of one frame showing value v with blank mask b.
    task automatic push_frame(input logic [7:0] v, input logic [1:0] b);
        exp_t       e;
        logic [3:0] nib;
        logic       dark;
        for (int d = 0; d < 2; d++) begin
            nib  = (d == 1) ? v[7:4] : v[3:0];
            dark = b[d];
`ifdef SEVSEG_LZB_EN
            if (d == 1 && v[7:4] == 4'h0) dark = 1'b1;
`endif
            for (int c = 0; c < 4; c++) begin
                e.an      = dark ? 2'b11 : ((d == 1) ? 2'b01 : 2'b10);
                e.seg     = dark ? 7'h7F : dec_tab[nib];
                e.seg_chk = !dark;
                e.fs      = (d == 0 && c == 0);
                exp_q.push_back(e);
            end
            e.an = 2'b11; e.seg = 7'h7F; e.seg_chk = 1'b1; e.fs = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Caller sits on the first sample of a frame; compares all ten cycles.
    task automatic check_frame(input string name);
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step(1);
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s: scoreboard empty at cycle %0d", name, i);
            end else begin
                e = exp_q.pop_front();
                if (an !== e.an || frame_start !== e.fs || (e.seg_chk && seg !== e.seg))
                    $display("FAIL %s cyc%0d: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                             name, i, an, seg, frame_start, e.an, e.seg, e.fs);
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic wait_frame(input string name, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        total_cnt++;
        if (frame_start !== 1'b1)
            $display("FAIL %s: frame_start timeout, got %b want 1", name, frame_start);
        else
            pass_cnt++;
    endtask

    task automatic test_reset;
        step(3);
        total_cnt++;
        if (seg !== 7'h7F || an !== 2'b11 || pending !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL reset_hold: got seg=%h an=%b pend=%b fs=%b, want 7f 11 0 0",
                     seg, an, pending, frame_start);
        else pass_cnt++;
        reset = 1'b0;
        push_frame(8'h00, 2'b00);
        step(1);
        check_frame("reset_first_frame");
    endtask

    task automatic test_display;
        int n;
        wait_frame("display_sync", n);
        total_cnt++;
        if (n !== 1) $display("FAIL frame_period: got %0d want 1 extra cycle", n);
        else pass_cnt++;
        do_load(8'h3A, 2'b00);
        total_cnt++;
        if (pending !== 1'b1) $display("FAIL display_pending: got %b want 1", pending);
        else pass_cnt++;
        push_frame(8'h3A, 2'b00);
        wait_frame("display_wait", n);
        total_cnt++;
        if (n !== 9) $display("FAIL display_latency: got %0d want 9", n);
        else pass_cnt++;
        check_frame("display_3A");
    endtask

    task automatic test_deferred;
        int n;
        wait_frame("deferred_sync", n);
        step(6);
        do_load(8'h77, 2'b00);
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (pending !== 1'b1 || an !== 2'b01 || seg !== dec_tab[3])
                $display("FAIL deferred_old%0d: got pend=%b an=%b seg=%b, want 1 01 %b",
                         i, pending, an, seg, dec_tab[3]);
            else pass_cnt++;
            if (i == 0) step(1);
        end
        push_frame(8'h77, 2'b00);
        wait_frame("deferred_wait", n);
        total_cnt++;
        if (pending !== 1'b0) $display("FAIL deferred_clear: got pend=%b want 0", pending);
        else pass_cnt++;
        check_frame("deferred_77");
    endtask

    task automatic test_double_load;
        int n;
        wait_frame("double_sync", n);
        do_load(8'h11, 2'b00);
        do_load(8'h22, 2'b00);
        push_frame(8'h22, 2'b00);
        wait_frame("double_wait", n);
        check_frame("double_22");
    endtask

    task automatic test_collision_blank;
        int n;
        wait_frame("collide_sync", n);
        do_load(8'h45, 2'b10);
        step(8);
        push_frame(8'h45, 2'b10);
        do_load(8'hF0, 2'b00);
        total_cnt++;
        if (pending !== 1'b1) $display("FAIL collide_pending: got %b want 1", pending);
        else pass_cnt++;
        check_frame("collide_old_blank");
        push_frame(8'hF0, 2'b00);
        wait_frame("collide_wait", n);
        total_cnt++;
        if (pending !== 1'b0) $display("FAIL collide_clear: got pend=%b want 0", pending);
        else pass_cnt++;
        check_frame("collide_F0");
    endtask

    task automatic test_lzb;
        int n;
        wait_frame("lzb_sync", n);
        do_load(8'h05, 2'b00);
        push_frame(8'h05, 2'b00);
        wait_frame("lzb_wait05", n);
        check_frame("lzb_05");
        wait_frame("lzb_sync00", n);
        do_load(8'h00, 2'b00);
        push_frame(8'h00, 2'b00);
        wait_frame("lzb_wait00", n);
        check_frame("lzb_00");
    endtask

    task automatic test_reset_mid;
        int n;
        wait_frame("rstmid_sync", n);
        do_load(8'h99, 2'b00);
        step(1);
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (seg !== 7'h7F || an !== 2'b11 || pending !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL reset_mid: got seg=%h an=%b pend=%b fs=%b, want 7f 11 0 0",
                     seg, an, pending, frame_start);
        else pass_cnt++;
        step(1);
        reset = 1'b0;
        push_frame(8'h00, 2'b00);
        wait_frame("rstmid_wait", n);
        total_cnt++;
        if (n !== 1) $display("FAIL reset_mid_restart: got %0d want 1", n);
        else pass_cnt++;
        check_frame("reset_mid_frame");
        total_cnt++;
        if (pending !== 1'b0) $display("FAIL reset_mid_discard: got pend=%b want 0", pending);
        else pass_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 8'h00;
        blank_in  = 2'b00;
        test_reset();
        test_display();
        test_deferred();
        test_double_load();
        test_collision_blank();
        test_lzb();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits sharing one segment bus. It holds a shadow and an active copy of the per-digit hex values and scans the digits round-robin with a programmable dwell and an anti-ghosting blank gap. New values are taken through a load strobe and applied only at a frame boundary. It sits between the lab's datapath (switches, adders, keypad) and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 2: number of digits scanned; must be at least 1.
- DIGIT_CYCLES, 100000: clock cycles each digit is lit per frame; must be at least 1.
- BLANK_CYCLES, 50: clock cycles with all anodes off after each digit dwell. 0 removes the gap.
- clk  in  1: system clock. There is one clock in this block.
- reset  in  1: asynchronous, active-high reset.
- load  in  1: single-cycle strobe that captures digits_in and blank_in into the shadow register.
- digits_in  in  4*NUM_DIGITS: hex value per digit. Nibble k drives digit k; digit 0 is least significant.
- blank_in  in  NUM_DIGITS: per-digit force-off mask (1 means the digit is dark).
- seg  out  7: segment drive, active-low, seg[0]=a through seg[6]=g.
- an  out  NUM_DIGITS: anode enables, active-low, one-hot-low during a dwell.
- frame_start  out  1: one-cycle pulse on the first dwell cycle of digit 0.
- pending  out  1: high while the shadow register holds an unapplied load.

## Operation
- The FSM has two states: DWELL and GAP. A digit index idx runs 0 to NUM_DIGITS-1. A down-counter cnt is sized $clog2 of max(DIGIT_CYCLES, BLANK_CYCLES, 2).
- In DWELL(idx), an[idx]=0 and all other anodes are 1. seg shows the decode of active[idx]. This lasts DIGIT_CYCLES cycles, then the FSM enters GAP.
- In GAP, an is all 1s and seg=7'h7F for BLANK_CYCLES cycles. The FSM then enters DWELL with idx+1, wrapping to 0 after NUM_DIGITS-1. When BLANK_CYCLES=0, DWELL goes straight to the next DWELL.
- Decode follows the 0–F table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- load=1 writes the shadow register and sets pending. A second load before the frame boundary overwrites the first; the last load wins.
- Frame boundary is the edge that enters DWELL(0). On that edge, if pending is set, the shadow register is copied to active, pending clears, and digit 0 already shows the new value.
  - If load and the boundary fall on the same edge, the boundary copies the old shadow contents. The new load is captured and pending stays 1.
- A digit with its active blank bit set keeps an=1 for its whole dwell. Dwell length does not change.

## Timing
- seg, an, frame_start and pending are all registered. They change only on clk rising edges, or asynchronously on reset.
- Reset values:
  - seg=7'h7F, an all 1s, frame_start=0, pending=0.
  - active and shadow cleared to 0, blank masks cleared.
  - FSM in GAP with idx=NUM_DIGITS-1 and cnt loaded for BLANK_CYCLES.
- After reset deasserts, DWELL(0) and frame_start begin after BLANK_CYCLES cycles (after 1 cycle when BLANK_CYCLES=0).
- Frame period is NUM_DIGITS*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- Load-to-display latency is at most one frame period plus 1 cycle.
- Reset asserted mid-dwell drives outputs to their reset values immediately and discards any pending load.

## Configuration
- SEVSEG_LZB_EN enables leading-zero blanking.
  - Defined: a digit k>0 is dark when active[k] and every more-significant active digit are 0. Digit 0 is always shown unless its blank_in bit is set.
  - Undefined: zeros display as 1000000. Only blank_in darkens digits.

## Structure
- sevseg_pkg holds:
  - typedef seg_t (logic [6:0]);
  - constant SEG_OFF = 7'h7F;
  - enum scan_state_t {DWELL, GAP}.
- One sub-module, hex_to_seg: a combinational nibble-to-seg_t decoder, instantiated once on the muxed active[idx] nibble.

## Test plan
All scenarios use NUM_DIGITS=2, DIGIT_CYCLES=4, BLANK_CYCLES=1.
- Reset: hold reset -> seg=7F, an=11, pending=0. Release -> 1 cycle of GAP, then frame_start=1 and an=10 with seg=1000000.
- Display: load digits_in=8'h3A -> at the next frame_start, an=10 and seg=0001000 for 4 cycles; an=11 for 1 cycle; an=01 and seg=0110000 for 4 cycles. Frame period is 10 cycles.
- Deferred update: load 8'h77 mid-dwell of digit 1 -> pending=1; digit 1 keeps its old value until frame_start; pending drops at frame_start.
- Double load: load 8'h11 then 8'h22 in one frame -> the next frame shows 2 on both digits.
- Boundary collision and blank mask:
  - load 8'hF0 on the frame_start edge -> this frame shows the old value and pending stays 1.
  - blank_in=2'b10 -> an[1] stays 1 through its dwell.
- Leading-zero blanking: load 8'h05.
  - With SEVSEG_LZB_EN, an[1] stays 1 and digit 0 shows 0010010.
  - Without it, digit 1 shows 1000000.
  - 8'h00 with the macro shows 1000000 on digit 0 only.
- Reset mid-dwell: assert reset asynchronously -> seg=7F and an=11 before the next clk edge; pending=0.
